multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB. It drives the enables and mux selects for PC, IR, register file, ALU, data memory and the immediate generator (ImmSel). It owns the memory request/ready handshake and a retired-instruction counter.

## Interface
No parameters.
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- INS  in  32  current IR contents (valid from DECODE onward)
- MEM_READY  in  1  memory completion; sampled only while MEM_REQ=1
- BR_TAKEN  in  1  ALU compare result; sampled only in EXEC of a branch
- MEM_REQ  out  1  memory access request
- MEM_WE  out  1  store when 1; qualifies MEM_REQ
- ADDR_SEL  out  1  memory address: 0=PC, 1=ALU result
- IR_WE  out  1  latch fetched word into IR
- ImmSel  out  1  immediate generator enable
- ALU_SRC_A  out  2  00=rs1, 01=PC, 10=zero
- ALU_SRC_B  out  1  0=rs2, 1=immediate
- ALU_CTRL  out  2  00=add, 01=branch compare (funct3), 10=funct3/funct7 decode
- REG_WE  out  1  register file write
- WB_SEL  out  2  00=ALU, 01=memory data, 10=PC+4
- PC_WE  out  1  PC update
- PC_SEL  out  2  00=PC+4, 01=PC+imm, 10=ALU result with bit0 cleared
- ILLEGAL  out  1  sticky illegal-opcode flag
- RETIRED_CNT  out  32  instructions completed

## Operation
- Legal opcodes:
  - R 0110011
  - I_COMP 0010011
  - LOAD 0000011
  - S 0100011
  - SB 1100011
  - JALR 1100111
  - LUI 0110111
  - AUIPC 0010111
- All other opcodes, including JAL, are illegal.
- Outputs are decoded from state and INS. Any output not listed for a state is 0.
- IDLE: all outputs 0. Always proceeds to FETCH.
- FETCH:
  - Outputs: MEM_REQ=1, ADDR_SEL=0.
  - Stays in FETCH while MEM_READY=0.
  - When MEM_READY=1: IR_WE=1 in the same cycle, next state DECODE.
- DECODE:
  - ImmSel=1.
  - Legal opcode → EXEC; illegal → TRAP.
- EXEC: ImmSel=1. Per opcode:
  - R: SRC_A=00, SRC_B=0, CTRL=10.
  - I_COMP: SRC_A=00, SRC_B=1, CTRL=10.
  - LOAD/S/JALR: SRC_A=00, SRC_B=1, CTRL=00.
  - LUI: SRC_A=10, SRC_B=1, CTRL=00.
  - AUIPC: SRC_A=01, SRC_B=1, CTRL=00.
  - SB: SRC_A=00, SRC_B=0, CTRL=01, PC_WE=1, PC_SEL=(BR_TAKEN ? 01 : 00). Instruction retires; next state FETCH.
  - LOAD/S → MEM; all others → WB.
- MEM:
  - ALU outputs held as in EXEC; ImmSel=1.
  - Outputs: MEM_REQ=1, ADDR_SEL=1, MEM_WE=1 for S.
  - Stays in MEM until MEM_READY=1.
  - On MEM_READY=1, S: PC_WE=1, PC_SEL=00, retires, next state FETCH.
  - On MEM_READY=1, LOAD: next state WB.
- WB:
  - ImmSel=1 and ALU selects held as in EXEC.
  - REG_WE=1 unless INS[11:7]==0.
  - WB_SEL: 01 for LOAD, 10 for JALR, else 00.
  - PC_WE=1; PC_SEL=10 for JALR, else 00.
  - Retires; next state FETCH.
- TRAP:
  - ILLEGAL=1; all other outputs 0.
  - Remains in TRAP until RST.
  - The offending instruction does not retire.
- RETIRED_CNT increments by 1 on each retiring cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- RST asserted asynchronously forces state IDLE, RETIRED_CNT=0 and ILLEGAL=0. All outputs read 0 while RST=1, including when reset hits mid-transfer.
- First FETCH occurs in the second cycle after RST deasserts (one IDLE cycle).
- Cycles per instruction with MEM_READY always 1:
  - SB: 3
  - R, I_COMP, LUI, AUIPC, JALR, S: 4
  - LOAD: 5
  - Each wait cycle with MEM_READY=0 adds one cycle.
- Handshake: MEM_REQ, MEM_WE and ADDR_SEL remain stable from the first request cycle through the cycle in which MEM_READY=1. MEM_READY is ignored when MEM_REQ=0.
- INS must remain stable from DECODE until the instruction retires.
- Exactly one PC_WE pulse per retired instruction. PC_WE and REG_WE are single-cycle pulses.

## Test plan
- Reset: assert RST during a LOAD's MEM wait → MEM_REQ drops to 0 immediately, RETIRED_CNT=0. After release: one IDLE cycle, then MEM_REQ=1, ADDR_SEL=0.
- ADD x3,x1,x2 (0x002081B3), MEM_READY=1:
  - IR_WE in cycle 1.
  - Cycle 4: REG_WE=1, WB_SEL=00, PC_WE=1, PC_SEL=00.
  - RETIRED_CNT 0→1.
- LW x5,8(x1) (0x0080A283) with MEM_READY low for 3 MEM cycles:
  - MEM_REQ=1, ADDR_SEL=1, MEM_WE=0 held for 4 cycles.
  - Then WB with WB_SEL=01 and REG_WE=1; total 8 cycles.
- BEQ x1,x2,+8 (0x00208463):
  - BR_TAKEN=1 → EXEC cycle has CTRL=01, PC_WE=1, PC_SEL=01, REG_WE=0; 3 cycles total.
  - Repeat with BR_TAKEN=0 → PC_SEL=00.
- JAL (0x0000006F): DECODE → TRAP. ILLEGAL=1 and stays set; no further MEM_REQ; RETIRED_CNT unchanged. RST clears ILLEGAL.
- ADDI x0,x0,0 (0x00000013): REG_WE stays 0 in WB, PC_WE=1, counter increments. Preload-free wrap check: 2^32 retirements not required; verify by forcing the counter to 0xFFFFFFFF, then one retirement → 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core: steps each instruction through
// IDLE/FETCH/DECODE/EXEC/MEM/WB, owns the memory handshake and the retired-instruction counter.
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INS,
  input  logic        MEM_READY,
  input  logic        BR_TAKEN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        ADDR_SEL,
  output logic        IR_WE,
  output logic        ImmSel,
  output logic [1:0]  ALU_SRC_A,
  output logic        ALU_SRC_B,
  output logic [1:0]  ALU_CTRL,
  output logic        REG_WE,
  output logic [1:0]  WB_SEL,
  output logic        PC_WE,
  output logic [1:0]  PC_SEL,
  output logic        ILLEGAL,
  output logic [31:0] RETIRED_CNT
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIComp  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic        retire;

  logic [6:0]  opcode;
  logic        rd_nonzero;
  logic        is_load, is_store, is_branch, is_jalr, is_legal;
  logic [1:0]  alu_a;
  logic        alu_b;
  logic [1:0]  alu_c;

  // Only the opcode and rd fields steer the sequencer.
  logic        unused_ins;
  assign unused_ins = ^INS[31:12];

  assign opcode     = INS[6:0];
  assign rd_nonzero = |INS[11:7];
  assign is_load    = (opcode == OpLoad);
  assign is_store   = (opcode == OpStore);
  assign is_branch  = (opcode == OpBranch);
  assign is_jalr    = (opcode == OpJalr);

  always_comb begin
    is_legal = 1'b1;
    alu_a    = 2'b00;
    alu_b    = 1'b0;
    alu_c    = 2'b00;
    case (opcode)
      OpR: begin
        alu_c = 2'b10;
      end
      OpIComp: begin
        alu_b = 1'b1;
        alu_c = 2'b10;
      end
      OpLoad, OpStore, OpJalr: begin
        alu_b = 1'b1;
      end
      OpLui: begin
        alu_a = 2'b10;
        alu_b = 1'b1;
      end
      OpAuipc: begin
        alu_a = 2'b01;
        alu_b = 1'b1;
      end
      OpBranch: begin
        alu_c = 2'b01;
      end
      default: begin
        is_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    ADDR_SEL  = 1'b0;
    IR_WE     = 1'b0;
    ImmSel    = 1'b0;
    ALU_SRC_A = 2'b00;
    ALU_SRC_B = 1'b0;
    ALU_CTRL  = 2'b00;
    REG_WE    = 1'b0;
    WB_SEL    = 2'b00;
    PC_WE     = 1'b0;
    PC_SEL    = 2'b00;
    ILLEGAL   = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        MEM_REQ = 1'b1;
        if (MEM_READY) begin
          IR_WE   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ImmSel  = 1'b1;
        state_d = is_legal ? StExec : StTrap;
      end
      StExec: begin
        ImmSel    = 1'b1;
        ALU_SRC_A = alu_a;
        ALU_SRC_B = alu_b;
        ALU_CTRL  = alu_c;
        if (is_branch) begin
          // Branches resolve here and never visit MEM or WB.
          PC_WE   = 1'b1;
          PC_SEL  = BR_TAKEN ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        ImmSel    = 1'b1;
        ALU_SRC_A = alu_a;
        ALU_SRC_B = alu_b;
        ALU_CTRL  = alu_c;
        MEM_REQ   = 1'b1;
        ADDR_SEL  = 1'b1;
        MEM_WE    = is_store;
        if (MEM_READY) begin
          if (is_store) begin
            PC_WE   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        ImmSel    = 1'b1;
        ALU_SRC_A = alu_a;
        ALU_SRC_B = alu_b;
        ALU_CTRL  = alu_c;
        REG_WE    = rd_nonzero;
        WB_SEL    = is_load ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        PC_WE     = 1'b1;
        PC_SEL    = is_jalr ? 2'b10 : 2'b00;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        ILLEGAL = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign retired_cnt_d = retired_cnt_q + {31'd0, retire};
  assign RETIRED_CNT   = retired_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      retired_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a reactive memory model, a per-instruction reference
// model pushing expected retire events, and a monitor that checks them as the DUT retires.
module tb_multicycle_ctrl;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIComp  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INS = 32'd0;
  logic        MEM_READY = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic        MEM_REQ, MEM_WE, ADDR_SEL, IR_WE, ImmSel, ALU_SRC_B, REG_WE, PC_WE, ILLEGAL;
  logic [1:0]  ALU_SRC_A, ALU_CTRL, WB_SEL, PC_SEL;
  logic [31:0] RETIRED_CNT;

  multicycle_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .INS        (INS),
    .MEM_READY  (MEM_READY),
    .BR_TAKEN   (BR_TAKEN),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .ADDR_SEL   (ADDR_SEL),
    .IR_WE      (IR_WE),
    .ImmSel     (ImmSel),
    .ALU_SRC_A  (ALU_SRC_A),
    .ALU_SRC_B  (ALU_SRC_B),
    .ALU_CTRL   (ALU_CTRL),
    .REG_WE     (REG_WE),
    .WB_SEL     (WB_SEL),
    .PC_WE      (PC_WE),
    .PC_SEL     (PC_SEL),
    .ILLEGAL    (ILLEGAL),
    .RETIRED_CNT(RETIRED_CNT)
  );

  always #5 CLK = ~CLK;

  logic [16:0] outs;
  assign outs = {MEM_REQ, MEM_WE, ADDR_SEL, IR_WE, ImmSel, ALU_SRC_A, ALU_SRC_B, ALU_CTRL,
                 REG_WE, WB_SEL, PC_WE, PC_SEL, ILLEGAL};

  typedef struct packed {
    logic [31:0] cyc;
    logic [16:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] cyc = 32'd0;
  int unsigned fw = 0;
  int unsigned mw = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  always @(posedge CLK) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory: stalls the fetch for fw cycles and the data access for mw cycles; otherwise noise.
  logic prev_req = 1'b0;
  logic prev_sel = 1'b0;
  always @(negedge CLK) begin
    static int unsigned k = 0;
    if (MEM_REQ && prev_req && (ADDR_SEL == prev_sel)) k++;
    else k = 0;
    if (MEM_REQ) MEM_READY = (k >= (ADDR_SEL ? mw : fw));
    else MEM_READY = 1'($urandom_range(0, 1));
    prev_req = MEM_REQ;
    prev_sel = ADDR_SEL;
  end

  function automatic int unsigned cycles_of(input logic [6:0] op);
    if (op == OpBranch) return 3;
    if (op == OpLoad) return 5;
    return 4;
  endfunction

  // Full output vector expected in the cycle an instruction retires (PC_WE high).
  function automatic logic [16:0] retire_outs(input logic [31:0] ins, input logic br);
    logic       req = 0, we = 0, asel = 0, b = 0, rwe = 0;
    logic [1:0] a = 0, c = 0, wb = 0, ps = 0;
    logic       rd = |ins[11:7];
    case (ins[6:0])
      OpR:      begin c = 2;                      rwe = rd; end
      OpIComp:  begin b = 1; c = 2;               rwe = rd; end
      OpLoad:   begin b = 1; wb = 1;              rwe = rd; end
      OpStore:  begin b = 1; req = 1; we = 1; asel = 1;   end
      OpBranch: begin c = 1; ps = br ? 2'd1 : 2'd0;       end
      OpJalr:   begin b = 1; wb = 2; ps = 2;      rwe = rd; end
      OpLui:    begin a = 2; b = 1;               rwe = rd; end
      OpAuipc:  begin a = 1; b = 1;               rwe = rd; end
      default:  ;
    endcase
    return {req, we, asel, 1'b0, 1'b1, a, b, c, rwe, wb, 1'b1, ps, 1'b0};
  endfunction

  // Called #1 after the rising edge that starts the instruction's first FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input int unsigned f, input int unsigned m,
                           input logic br);
    exp_t        e;
    int unsigned n;
    n = cycles_of(ins[6:0]) + f + (((ins[6:0] == OpLoad) || (ins[6:0] == OpStore)) ? m : 0);
    e.cyc  = cyc + n - 1;
    e.outs = retire_outs(ins, br);
    e.cnt  = model_cnt;
    sb_q.push_back(e);
    model_cnt = model_cnt + 32'd1;
    INS      = ins;
    fw       = f;
    mw       = m;
    BR_TAKEN = br;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: pops an expectation on every retire and checks per-cycle invariants.
  logic       p_req = 0, p_rdy = 0, p_pcwe = 0;
  logic [2:0] p_hs = 0;
  always begin
    exp_t e;
    @(negedge CLK);
    #1;
    if (mon_en && !RST) begin
      if (PC_WE) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected retire: got outs %h, want none", outs);
        end else begin
          e = sb_q.pop_front();
          check("retire cycle", cyc, e.cyc);
          check("retire outputs", {15'd0, outs}, {15'd0, e.outs});
          check("count at retire", RETIRED_CNT, e.cnt);
        end
        check("pc_we single pulse", {31'd0, p_pcwe}, 32'd0);
      end
      if (REG_WE) check("reg_we with pc_we", {31'd0, PC_WE}, 32'd1);
      if (IR_WE) check("ir_we qualifier", {29'd0, MEM_REQ, ADDR_SEL, MEM_READY}, 32'd5);
      if (p_req && !p_rdy) check("handshake hold", {29'd0, MEM_REQ, MEM_WE, ADDR_SEL},
                                 {29'd0, p_hs});
      check("illegal low", {31'd0, ILLEGAL}, 32'd0);
    end
    p_req  = MEM_REQ;
    p_rdy  = MEM_READY;
    p_pcwe = PC_WE;
    p_hs   = {MEM_REQ, MEM_WE, ADDR_SEL};
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  ops[8];
    ops = '{OpR, OpIComp, OpLoad, OpStore, OpBranch, OpJalr, OpLui, OpAuipc};

    repeat (2) @(negedge CLK);
    #1;
    check("reset outputs", {15'd0, outs}, 32'd0);
    check("reset count", RETIRED_CNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("idle outputs", {15'd0, outs}, 32'd0);
    @(posedge CLK);
    #1;
    check("first fetch", {30'd0, MEM_REQ, ADDR_SEL}, 32'd2);
    mon_en = 1'b1;

    run_instr(32'h002081B3, 0, 0, 1'b0);  // add x3,x1,x2
    check("count after add", RETIRED_CNT, 32'd1);
    run_instr(32'h0080A283, 0, 3, 1'b0);  // lw x5,8(x1), three wait cycles
    run_instr(32'h00208463, 0, 0, 1'b1);  // beq taken
    run_instr(32'h00208463, 1, 0, 1'b0);  // beq not taken
    run_instr(32'h00000013, 0, 0, 1'b0);  // addi x0,x0,0

    for (int i = 0; i < 400; i++) begin
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 7)]};
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    check("scoreboard drained", sb_q.size(), 32'd0);
    check("count after run", RETIRED_CNT, model_cnt);

    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    run_instr(32'h00000013, 0, 0, 1'b0);
    check("count wrap", RETIRED_CNT, 32'd0);

    // JAL is illegal: sequencer parks in TRAP.
    mon_en = 1'b0;
    INS = 32'h0000006F;
    fw  = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("illegal set", {31'd0, ILLEGAL}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      #1;
      check("trap outputs", {15'd0, outs}, 32'd1);
      check("trap count", RETIRED_CNT, 32'd0);
    end
    RST = 1'b1;
    #1;
    check("reset clears illegal", {31'd0, ILLEGAL}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    model_cnt = 32'd0;
    mon_en = 1'b1;
    run_instr(32'h002081B3, 0, 0, 1'b0);
    check("count before mid reset", RETIRED_CNT, 32'd1);

    // Reset lands in the middle of a load's data wait.
    mon_en = 1'b0;
    INS = 32'h0080A283;
    fw  = 0;
    mw  = 20;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("load mem wait", {29'd0, MEM_REQ, ADDR_SEL, MEM_WE}, 32'd6);
    #1;
    RST = 1'b1;
    #1;
    check("mid reset outputs", {15'd0, outs}, 32'd0);
    check("mid reset count", RETIRED_CNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("idle after reset", {15'd0, outs}, 32'd0);
    @(posedge CLK);
    #1;
    check("fetch after reset", {30'd0, MEM_REQ, ADDR_SEL}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
